seq_mac_neuron: RTL
===================

# seq_mac_neuron

Parametrised, time-multiplexed successor to the fixed 8-input combinational neuron. It accepts one signed (x, w) pair per cycle over a valid/ready stream and accumulates the products plus a bias in a wide internal register. The result is a saturated, optionally ReLU-activated output, with its own valid/ready handshake. It sits between the layer weight/activation sequencer and the next layer's input buffer, and is the building block for both hidden and output layers.

## Interface
- `DATA_W`, 8: width of x, w, bias and out_val (signed two's complement).
- `N_IN`, 8: number of (x, w) pairs per neuron evaluation; must be ≥ 1.
- `FRAC`, 0: fractional bits of the shared Q format for x, w, bias and out_val.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin an evaluation; sampled only in IDLE.
- `bias`  in  DATA_W  signed bias; captured with start.
- `act_mode`  in  1  0 = linear, 1 = ReLU; captured with start.
- `in_valid`  in  1  x/w pair present.
- `in_ready`  out  1  block accepts a pair this cycle.
- `x`, `w`  in  DATA_W each  signed operand pair.
- `out_valid`  out  1  out_val holds a result.
- `out_ready`  in  1  downstream consumes the result.
- `out_val`  out  DATA_W  signed activated result.
- `sat`  out  1  the result was clipped by saturation; valid with out_valid.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, ACCUM, OUT.
- **IDLE**
  - in_ready=0.
  - When start=1: acc ← sign-extended bias <<< FRAC, cnt ← 0, mode register ← act_mode, then go to ACCUM.
- **ACCUM**
  - in_ready=1.
  - Each cycle with in_valid & in_ready: acc ← acc + x*w (full 2·DATA_W signed product), cnt ← cnt+1.
  - On the beat where cnt == N_IN−1, register the result and go to OUT.
  - Cycles with in_valid=0 leave acc and cnt unchanged.
- **OUT**
  - out_valid=1; out_val and sat are held stable.
  - When out_ready=1, go to IDLE.
- start is ignored outside IDLE.
- Arithmetic:
  - ACC_W = 2·DATA_W + clog2(N_IN+1) + 1, so the accumulator never wraps.
  - r = acc >>> FRAC (arithmetic shift, truncates toward −∞).
  - Clip r to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; sat=1 if clipped.
  - If mode=ReLU and the clipped value is < 0, the output is 0. sat still reflects the clip.
- An asynchronous reset in any state returns to IDLE, discards the partial accumulation, and clears all outputs.

## Timing
- Reset values: in_ready=0, out_valid=0, out_val=0, sat=0, busy=0; acc, cnt and mode are cleared to 0.
- start sampled at edge t puts the block in ACCUM with in_ready=1 from t+1.
- The last pair accepted at edge t gives out_valid=1 with the final out_val from t+1 (1-cycle latency).
- Minimum period per evaluation: N_IN + 2 cycles (start, N_IN beats, 1 OUT cycle with out_ready=1).
- The output handshake completes on the edge where out_valid & out_ready; out_valid=0 from the next cycle.
- in_ready is combinational from state only, with no dependence on in_valid. out_valid is registered.
- Simultaneous start and out handshake in OUT: start is ignored; it must be reasserted in IDLE.

## Structure
- Package `nn_pkg` holds:
  - `act_mode_e` (ACT_LINEAR=0, ACT_RELU=1).
  - `neuron_state_e` (IDLE, ACCUM, OUT).
  - The ACC_W width function.
- Sub-module `nn_sat_act`: purely combinational shift / saturate / ReLU from ACC_W to DATA_W, producing the result and the sat flag. It will be reused by later pooling and normalisation blocks.
- The top level holds the FSM, the counter, and the MAC register.

## Test plan
- DATA_W=8, N_IN=8, FRAC=0, linear, bias=0, x=1, w=1..8 → out_val=36, sat=0, out_valid exactly 1 cycle after the 8th beat.
- x=127, w=127 for all 8 pairs → out_val=127, sat=1. Then x=−128, w=127 for all 8 pairs → out_val=−128 (0x80), sat=1.
- bias=5, x=−1, w=10 for all 8 pairs:
  - Linear → out_val=−75 (0xB5), sat=0.
  - ReLU → out_val=0, sat=0.
- Backpressure:
  - Random in_valid gaps give the same result as the gap-free run.
  - With out_ready held low for 5 cycles, out_val/sat stay stable, in_ready=0, and a start pulse is ignored.
  - Raising out_ready returns the block to IDLE next cycle.
- Assert rst_n low after 3 accepted beats → all outputs 0 immediately. A fresh evaluation after reset yields the correct result, with no residue from the aborted one.
- FRAC=4, N_IN=2, bias=0x04 (0.25), pairs (0x10, 0x20) (1.0·2.0) and (0x08, 0xF0) (0.5·−1.0) → out_val=0x1C (1.75), sat=0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types for the sequential neuron family:
// activation modes, FSM states and accumulator sizing.
package nn_pkg;

  typedef enum logic {
    ACT_LINEAR = 1'b0,
    ACT_RELU   = 1'b1
  } act_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } neuron_state_e;

  // Wide enough that N_IN full products plus the bias cannot wrap.
  function automatic int acc_w(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in + 1) + 1;
  endfunction

endpackage

// File: rtl/seq_mac_neuron_if.sv
// Control, operand stream and result stream of one neuron.
// master = sequencer side, slave = neuron side.
interface seq_mac_neuron_if #(
  parameter int DATA_W = 8
);
  logic                     start;
  logic signed [DATA_W-1:0] bias;
  logic                     act_mode;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] w;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_val;
  logic                     sat;
  logic                     busy;

  modport master (
    output start, bias, act_mode,
    output in_valid, x, w, out_ready,
    input  in_ready, out_valid,
    input  out_val, sat, busy
  );

  modport slave (
    input  start, bias, act_mode,
    input  in_valid, x, w, out_ready,
    output in_ready, out_valid,
    output out_val, sat, busy
  );
endinterface

// File: rtl/nn_sat_act.sv
// Fixed-point rescale, saturation and optional ReLU
// from a wide accumulator down to the data width.
module nn_sat_act
  import nn_pkg::*;
#(
  parameter int IN_W  = 21,
  parameter int OUT_W = 8,
  parameter int FRAC  = 0
) (
  input  logic signed [IN_W-1:0]  acc,
  input  act_mode_e               mode,
  output logic signed [OUT_W-1:0] res,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN =
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0]  r;
  logic signed [OUT_W-1:0] clip;

  // shift toward -inf, clamp, then apply ReLU to the clamped value
  always_comb begin
    r    = acc >>> FRAC;
    clip = r[OUT_W-1:0];
    sat  = 1'b0;
    if (r > MAX) begin
      clip = MAX[OUT_W-1:0];
      sat  = 1'b1;
    end else if (r < MIN) begin
      clip = MIN[OUT_W-1:0];
      sat  = 1'b1;
    end
    res = clip;
    if (mode == ACT_RELU && clip[OUT_W-1])
      res = '0;
  end

endmodule

// File: rtl/seq_mac_neuron.sv
// Time-multiplexed neuron: one (x, w) pair per beat
// into a wide MAC, result held until consumed.
module seq_mac_neuron
  import nn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_IN   = 8,
  parameter int FRAC   = 0
) (
  input logic clk,
  input logic rst_n,
  seq_mac_neuron_if.slave bus
);

  localparam int ACC_W  = acc_w(DATA_W, N_IN);
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

  neuron_state_e state;
  neuron_state_e state_nxt;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [PROD_W-1:0] prod;
  logic [CNT_W-1:0]         cnt;
  act_mode_e                mode;
  logic                     beat;
  logic                     last;
  logic signed [DATA_W-1:0] res;
  logic                     res_sat;
  logic signed [DATA_W-1:0] val_q;
  logic                     sat_q;

  assign prod = bus.x * bus.w;
  assign acc_sum = acc +
    {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext =
    {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias}
    <<< FRAC;

  assign beat = (state == ACCUM) && bus.in_valid;
  assign last = beat && (cnt == CNT_W'(N_IN - 1));

  nn_sat_act #(
    .IN_W (ACC_W),
    .OUT_W(DATA_W),
    .FRAC (FRAC)
  ) u_sat_act (
    .acc (acc_sum),
    .mode(mode),
    .res (res),
    .sat (res_sat)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start)     state_nxt = ACCUM;
      ACCUM:   if (last)          state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // MAC, beat counter, captured mode and result hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      mode  <= ACT_LINEAR;
      val_q <= '0;
      sat_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      acc  <= bias_ext;
      cnt  <= '0;
      mode <= act_mode_e'(bus.act_mode);
    end else if (beat) begin
      acc <= acc_sum;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        val_q <= res;
        sat_q <= res_sat;
      end
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == OUT);
  assign bus.busy      = (state != IDLE);
  assign bus.out_val   = val_q;
  assign bus.sat       = sat_q;

endmodule
